// File: rtl/serv_load_ser_pkg.sv
// Shared constants for the serial load unit: access sizes, FSM states and
// the helper that aligns and extends a bus word before it is shifted out.
package serv_load_ser_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_READY,
    S_SHIFT
  } state_t;

  // Extension is applied once at capture so the shifter only ever fills with zeros.
  function automatic logic [31:0] load_align(input logic [31:0] rdt,
                                             input logic [1:0]  lsb,
                                             input logic [1:0]  size,
                                             input logic        sext);
    logic [31:0] d;
    d = rdt >> {lsb, 3'b000};
    case (size)
      SIZE_BYTE: load_align = {{24{sext & d[7]}}, d[7:0]};
      SIZE_HALF: load_align = {{16{sext & d[15]}}, d[15:0]};
      default:   load_align = d;
    endcase
  endfunction

endpackage

// File: rtl/serv_load_ser_if.sv
// Data bus handshake between the serial load unit and the memory side.
interface serv_load_ser_if;
  logic [31:0] o_dbus_adr;
  logic        o_dbus_cyc;
  logic [31:0] i_dbus_rdt;
  logic        i_dbus_ack;

  modport master (
    output o_dbus_adr,
    output o_dbus_cyc,
    input  i_dbus_rdt,
    input  i_dbus_ack
  );

  modport slave (
    input  o_dbus_adr,
    input  o_dbus_cyc,
    output i_dbus_rdt,
    output i_dbus_ack
  );
endinterface

// File: rtl/serv_load_ser.sv
// Serial load unit: fetches one bus word, aligns/extends it, then streams it
// out LSB first, one bit per enabled cycle, pulsing o_done after 32 bits.
module serv_load_ser
  import serv_load_ser_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req,
  input  logic [31:0]            i_adr,
  input  logic [1:0]             i_size,
  input  logic                   i_signed,
  input  logic                   i_en,
  serv_load_ser_if.master        dbus,
  output logic                   o_rdy,
  output logic [W-1:0]           o_q,
  output logic                   o_done
);

  if (W != 1) begin : g_w_check
    $fatal(1, "serv_load_ser: only W=1 is supported");
  end

  state_t      state;
  logic [31:0] data;
  logic [4:0]  cnt;
  logic [1:0]  lsb;
  logic [1:0]  size;
  logic        sext;
  logic        active;

  assign active = (state == S_READY) || (state == S_SHIFT);
  assign o_q    = {W{active & i_en & data[0]}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      dbus.o_dbus_adr <= '0;
      dbus.o_dbus_cyc <= 1'b0;
      lsb             <= '0;
      size            <= '0;
      sext            <= 1'b0;
      data            <= '0;
      cnt             <= '0;
      o_rdy           <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle is already IDLE, so a request there is masked.
          if (i_req && !o_done) begin
            dbus.o_dbus_adr <= {i_adr[31:2], 2'b00};
            lsb             <= i_adr[1:0];
            size            <= i_size;
            sext            <= i_signed;
            dbus.o_dbus_cyc <= 1'b1;
            state           <= S_BUS;
          end
        end
        S_BUS: begin
          if (dbus.i_dbus_ack) begin
            data            <= load_align(dbus.i_dbus_rdt, lsb, size, sext);
            dbus.o_dbus_cyc <= 1'b0;
            o_rdy           <= 1'b1;
            state           <= S_READY;
          end
        end
        S_READY: begin
          if (i_en) begin
            data  <= {1'b0, data[31:1]};
            cnt   <= cnt + 5'd1;
            o_rdy <= 1'b0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_en) begin
            data <= {1'b0, data[31:1]};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              o_done <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_load_ser.sv
// Directed bench for serv_load_ser: table of loads plus reset and
// back-to-back sequences, with hand-computed expected words.
module tb_serv_load_ser;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] adr_in;
  logic [1:0]  size_in;
  logic        sg_in;
  logic        en;
  logic        rdy;
  logic [0:0]  q;
  logic        done;

  serv_load_ser_if dbus ();

  serv_load_ser #(.W(1)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_adr    (adr_in),
    .i_size   (size_in),
    .i_signed (sg_in),
    .i_en     (en),
    .dbus     (dbus),
    .o_rdy    (rdy),
    .o_q      (q),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [1:0]  size;
    logic        sg;
    logic [31:0] rdt;
    int          dly;
    bit          gap;
    bit          ack_req;
    logic [31:0] exp_val;
    logic [31:0] exp_adr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  // Called at a negedge: issues the request and checks the BUS entry one cycle later.
  task automatic start_req(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                           input bit ack_req, input logic [31:0] exp_adr, input string name);
    req = 1'b1; adr_in = a; size_in = sz; sg_in = sg;
    dbus.i_dbus_ack = ack_req; dbus.i_dbus_rdt = 32'hDEAD_BEEF;
    @(negedge clk);
    req = 1'b0; dbus.i_dbus_ack = 1'b0;
    #1;
    check({name, " cyc_up"}, {31'b0, dbus.o_dbus_cyc}, 32'd1);
    check({name, " rdy_bus"}, {31'b0, rdy}, 32'd0);
    check({name, " adr"}, dbus.o_dbus_adr, exp_adr);
  endtask

  // Completes BUS and SHIFT; returns at the done negedge with o_done checked.
  task automatic finish(input logic [31:0] rdt, input int dly, input bit gap,
                        input logic [31:0] exp_val, input logic [31:0] exp_adr,
                        input bit req_at_done, input string name);
    int bad;
    logic [31:0] got;
    bad = 0;
    got = '0;
    for (int i = 0; i < dly; i++) begin
      req = 1'b1; adr_in = 32'h0BAD_0000 + 32'(i);
      @(negedge clk);
      req = 1'b0;
      #1;
      if (dbus.o_dbus_cyc !== 1'b1 || rdy !== 1'b0) bad++;
    end
    dbus.i_dbus_ack = 1'b1; dbus.i_dbus_rdt = rdt;
    @(negedge clk);
    dbus.i_dbus_ack = 1'b0; dbus.i_dbus_rdt = 32'hFFFF_FFFF;
    #1;
    check({name, " cyc_drop"}, {31'b0, dbus.o_dbus_cyc}, 32'd0);
    check({name, " rdy"}, {31'b0, rdy}, 32'd1);
    check({name, " adr_hold"}, dbus.o_dbus_adr, exp_adr);
    for (int b = 0; b < 32; b++) begin
      if (gap && b > 0) begin
        en = 1'b0; req = 1'b1; adr_in = $urandom;
        #1;
        if (q !== 1'b0 || done !== 1'b0 || rdy !== 1'b0) bad++;
        @(negedge clk);
      end
      en = 1'b1; req = 1'b1; adr_in = $urandom;
      #1;
      got[b] = q[0];
      if (done !== 1'b0) bad++;
      @(negedge clk);
    end
    en = 1'b0;
    req = req_at_done; adr_in = 32'h0000_0900;
    #1;
    check({name, " done"}, {31'b0, done}, 32'd1);
    check({name, " value"}, got, exp_val);
    check({name, " cycle_errs"}, 32'(bad), 32'd0);
  endtask

  task automatic after_done(input string name);
    @(negedge clk);
    req = 1'b0;
    #1;
    check({name, " done_clr"}, {31'b0, done}, 32'd0);
    check({name, " cyc_idle"}, {31'b0, dbus.o_dbus_cyc}, 32'd0);
  endtask

  initial begin
    //            adr           size   sg    rdt           dly gap ackreq exp_val       exp_adr
    vecs[0] = '{32'h0000_0100, 2'b10, 1'b0, 32'hA5A5_0F0F, 3, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0000_0100};
    vecs[1] = '{32'h0000_0203, 2'b00, 1'b1, 32'h8000_0000, 1, 1'b0, 1'b0, 32'hFFFF_FF80, 32'h0000_0200};
    vecs[2] = '{32'h0000_0302, 2'b01, 1'b0, 32'hFFFF_1234, 2, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0300};
    vecs[3] = '{32'h0000_1004, 2'b10, 1'b0, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_1004};
    vecs[4] = '{32'h0000_0040, 2'b11, 1'b1, 32'h8000_0001, 0, 1'b0, 1'b0, 32'h8000_0001, 32'h0000_0040};
    vecs[5] = '{32'h0000_0055, 2'b00, 1'b0, 32'h1234_ABCD, 2, 1'b0, 1'b0, 32'h0000_00AB, 32'h0000_0054};
    vecs[6] = '{32'hFFFF_FFF0, 2'b01, 1'b1, 32'h0000_8001, 1, 1'b0, 1'b0, 32'hFFFF_8001, 32'hFFFF_FFF0};
    vecs[7] = '{32'h0000_0007, 2'b01, 1'b1, 32'hFF00_0000, 1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0004};
    vecs[8] = '{32'h0000_0002, 2'b00, 1'b1, 32'h007F_0000, 0, 1'b0, 1'b0, 32'h0000_007F, 32'h0000_0000};
    vecs[9] = '{32'h0000_0800, 2'b10, 1'b0, 32'h0F0F_1234, 2, 1'b0, 1'b1, 32'h0F0F_1234, 32'h0000_0800};

    rst_n = 1'b0; req = 1'b0; adr_in = 32'h0000_0123; size_in = 2'b10; sg_in = 1'b0;
    en = 1'b1; dbus.i_dbus_ack = 1'b0; dbus.i_dbus_rdt = 32'hFFFF_FFFF;
    #3;
    check("reset cyc", {31'b0, dbus.o_dbus_cyc}, 32'd0);
    check("reset rdy", {31'b0, rdy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset q", {31'b0, q}, 32'd0);
    check("reset adr", dbus.o_dbus_adr, 32'd0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      start_req(vecs[r].adr, vecs[r].size, vecs[r].sg, vecs[r].ack_req, vecs[r].exp_adr,
                $sformatf("row%0d", r));
      finish(vecs[r].rdt, vecs[r].dly, vecs[r].gap, vecs[r].exp_val, vecs[r].exp_adr,
             1'b0, $sformatf("row%0d", r));
      after_done($sformatf("row%0d", r));
    end

    // Back-to-back: request on the done cycle is dropped, the next cycle's is taken.
    @(negedge clk);
    start_req(32'h0000_0A00, 2'b10, 1'b0, 1'b0, 32'h0000_0A00, "b2b_first");
    finish(32'hC3C3_5A5A, 1, 1'b0, 32'hC3C3_5A5A, 32'h0000_0A00, 1'b1, "b2b_first");
    @(negedge clk);
    req = 1'b0;
    #1;
    check("b2b ignored_cyc", {31'b0, dbus.o_dbus_cyc}, 32'd0);
    check("b2b ignored_adr", dbus.o_dbus_adr, 32'h0000_0A00);
    start_req(32'h0000_0904, 2'b10, 1'b0, 1'b0, 32'h0000_0904, "b2b_second");
    finish(32'h0102_0304, 0, 1'b0, 32'h0102_0304, 32'h0000_0904, 1'b0, "b2b_second");
    after_done("b2b_second");

    // Reset while presenting bit 10, with a late ack held across reset.
    @(negedge clk);
    start_req(32'h0000_0500, 2'b10, 1'b0, 1'b0, 32'h0000_0500, "rst_mid");
    dbus.i_dbus_ack = 1'b1; dbus.i_dbus_rdt = 32'hFFFF_FFFF;
    @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("rst_mid bit10_q", {31'b0, q}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid q", {31'b0, q}, 32'd0);
    check("rst_mid cyc", {31'b0, dbus.o_dbus_cyc}, 32'd0);
    check("rst_mid rdy", {31'b0, rdy}, 32'd0);
    check("rst_mid done", {31'b0, done}, 32'd0);
    check("rst_mid adr", dbus.o_dbus_adr, 32'd0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("late_ack cyc", {31'b0, dbus.o_dbus_cyc}, 32'd0);
    check("late_ack rdy", {31'b0, rdy}, 32'd0);
    dbus.i_dbus_ack = 1'b0;
    @(negedge clk);
    start_req(32'h0000_0600, 2'b10, 1'b0, 1'b0, 32'h0000_0600, "post_rst");
    finish(32'h1357_9BDF, 2, 1'b0, 32'h1357_9BDF, 32'h0000_0600, 1'b0, "post_rst");
    after_done("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
